// File: rtl/frog_move_arbiter.sv
// Round-robin move arbiter for the frog: one move per grant, then a lockout.
// Define FROG_AUTOREPEAT_EN to add held-button auto-repeat.
module frog_move_arbiter #(
  parameter logic [15:0] LOCKOUT_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_CYCLES  = 24'd12500000
) (
  input  logic       F_CLOCK_50,
  input  logic       F_RESET,
  input  logic [3:0] F_BTN_PULSE,
  input  logic [3:0] F_BTN_LEVEL,
  output logic       F_MOVE_VALID,
  output logic [1:0] F_MOVE_DIR,
  input  logic       F_MOVE_ACK,
  output logic       F_BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    COOLDOWN
  } state_e;

  localparam logic [15:0] LOCK_LAST = LOCKOUT_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  clear;
  logic [3:0]  rpt_set;
  logic [1:0]  last_q, last_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  pick;
  logic [15:0] cnt_q, cnt_d;

  // Lowest offset from last_grant+1 wins; walk offsets high to low.
  always_comb begin : rr_pick
    logic [1:0] idx;
    idx  = 2'd0;
    pick = last_q + 2'd1;
    for (int i = 3; i >= 0; i--) begin
      idx = last_q + 2'd1 + 2'(i);
      if (pend_q[idx]) pick = idx;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    clear   = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = GRANT;
          dir_d   = pick;
        end
      end
      GRANT: begin
        if (F_MOVE_ACK) begin
          clear   = 4'b0001 << dir_q;
          last_d  = dir_q;
          cnt_d   = LOCK_LAST;
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A pulse coinciding with its own clear survives.
    pend_d = (pend_q & ~clear) | F_BTN_PULSE | rpt_set;
  end

  always_ff @(posedge F_CLOCK_50 or posedge F_RESET) begin
    if (F_RESET) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      last_q  <= 2'd3;
      cnt_q   <= 16'd0;
      dir_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

`ifdef FROG_AUTOREPEAT_EN
  localparam logic [23:0] RPT_LAST = REPEAT_CYCLES - 24'd1;

  logic [23:0] hold_q, hold_d;
  logic [3:0]  lvl_q;
  logic        one_hot;

  assign one_hot = $onehot(F_BTN_LEVEL);

  // Hold timer freezes in GRANT so a stalled move does not queue repeats.
  always_comb begin
    hold_d  = hold_q;
    rpt_set = 4'b0000;
    if (|F_BTN_PULSE || (F_BTN_LEVEL != lvl_q) || !one_hot) begin
      hold_d = 24'd0;
    end else if (state_q != GRANT) begin
      if (hold_q == RPT_LAST) begin
        hold_d  = 24'd0;
        rpt_set = F_BTN_LEVEL;
      end else begin
        hold_d = hold_q + 24'd1;
      end
    end
  end

  always_ff @(posedge F_CLOCK_50 or posedge F_RESET) begin
    if (F_RESET) begin
      hold_q <= 24'd0;
      lvl_q  <= 4'b0000;
    end else begin
      hold_q <= hold_d;
      lvl_q  <= F_BTN_LEVEL;
    end
  end
`else
  logic unused_lvl;
  assign unused_lvl = ^{F_BTN_LEVEL, REPEAT_CYCLES};
  assign rpt_set    = 4'b0000;
`endif

  assign F_MOVE_VALID = (state_q == GRANT);
  assign F_BUSY       = (state_q != IDLE);
  assign F_MOVE_DIR   = dir_q;

endmodule

// File: tb/tb_frog_move_arbiter.sv
// Directed bench for frog_move_arbiter, LOCKOUT_CYCLES=4, REPEAT_CYCLES=8.
// Default build: auto-repeat disabled.
module tb_frog_move_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pulse = 4'b0000;
  logic [3:0] level = 4'b0000;
  logic       ack = 1'b0;
  logic       valid;
  logic [1:0] dir;
  logic       busy;

  int vecs  = 0;
  int fails = 0;
  int ngr;

  frog_move_arbiter #(
    .LOCKOUT_CYCLES(16'd4),
    .REPEAT_CYCLES (24'd8)
  ) dut (
    .F_CLOCK_50  (clk),
    .F_RESET     (rst),
    .F_BTN_PULSE (pulse),
    .F_BTN_LEVEL (level),
    .F_MOVE_VALID(valid),
    .F_MOVE_DIR  (dir),
    .F_MOVE_ACK  (ack),
    .F_BUSY      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_once(input logic [3:0] p);
    pulse = p;
    step();
    pulse = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    step();
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_dir", {6'd0, dir}, 8'd0);
    rst = 1'b0;
    step();
    chk("idle_valid", {7'd0, valid}, 8'd0);

    // Single pulse on left, ack held high
    ack = 1'b1;
    pulse_once(4'b0100);
    chk("sp_pend_valid", {7'd0, valid}, 8'd0);
    step();
    chk("sp_valid", {7'd0, valid}, 8'd1);
    chk("sp_dir", {6'd0, dir}, 8'd2);
    chk("sp_busy", {7'd0, busy}, 8'd1);
    step();
    chk("sp_valid_drop", {7'd0, valid}, 8'd0);
    chk("sp_cd_busy0", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sp_cd_busy", {7'd0, busy}, 8'd1);
    end
    step();
    chk("sp_idle_busy", {7'd0, busy}, 8'd0);

    // Round-robin from reset priority
    do_reset();
    pulse_once(4'b1111);
    for (int d = 0; d < 4; d++) begin
      step();
      chk("rr_valid", {7'd0, valid}, 8'd1);
      chk("rr_dir", {6'd0, dir}, 8'(d));
      for (int c = 0; c < 4; c++) begin
        step();
        chk("rr_cd_valid", {7'd0, valid}, 8'd0);
        chk("rr_cd_busy", {7'd0, busy}, 8'd1);
      end
      step();
      chk("rr_idle_busy", {7'd0, busy}, 8'd0);
    end
    step();
    chk("rr_done_valid", {7'd0, valid}, 8'd0);

    // Stall in GRANT with collapsing up pulses
    ack = 1'b0;
    pulse_once(4'b0010);
    step();
    chk("st_valid", {7'd0, valid}, 8'd1);
    chk("st_dir", {6'd0, dir}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      if (i == 3 || i == 8 || i == 13) pulse = 4'b0001;
      step();
      pulse = 4'b0000;
      chk("st_hold_valid", {7'd0, valid}, 8'd1);
      chk("st_hold_dir", {6'd0, dir}, 8'd1);
    end
    ack = 1'b1;
    step();
    chk("st_ack_valid", {7'd0, valid}, 8'd0);
    for (int i = 0; i < 3; i++) step();
    chk("st_cd_busy", {7'd0, busy}, 8'd1);
    step();
    chk("st_idle_busy", {7'd0, busy}, 8'd0);
    step();
    chk("st_g2_valid", {7'd0, valid}, 8'd1);
    chk("st_g2_dir", {6'd0, dir}, 8'd0);
    for (int i = 0; i < 5; i++) step();
    chk("st_after_busy", {7'd0, busy}, 8'd0);
    step();
    chk("st_one_grant", {7'd0, valid}, 8'd0);

    // Reset during COOLDOWN with left still pending
    pulse_once(4'b0110);
    step();
    chk("rm_dir", {6'd0, dir}, 8'd1);
    step();
    step();
    chk("rm_cd_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    #1;
    chk("rm_valid", {7'd0, valid}, 8'd0);
    chk("rm_busy", {7'd0, busy}, 8'd0);
    chk("rm_dir0", {6'd0, dir}, 8'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("rm_lost_valid", {7'd0, valid}, 8'd0);
    chk("rm_lost_busy", {7'd0, busy}, 8'd0);
    pulse_once(4'b1000);
    step();
    chk("rm_r_valid", {7'd0, valid}, 8'd1);
    chk("rm_r_dir", {6'd0, dir}, 8'd3);

    // Held level without auto-repeat: a single grant only
    do_reset();
    level = 4'b0001;
    pulse_once(4'b0001);
    ngr = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid) ngr++;
    end
    level = 4'b0000;
    chk("ar_grants", 8'(ngr), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
